// File: rtl/ram16k_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram16k_pkg
// Purpose  : Shared widths, state encoding and mode constants for the
//            RAM16k DMA engine.
// Revision : 1.0 - initial release
// ============================================================================
package ram16k_pkg;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_WRITE  = 3'd2,
        ST_VERIFY = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    // Copy needs a read before every write; fill writes back-to-back.
    function automatic state_e xfer_state(input logic mode);
        return (mode == MODE_FILL) ? ST_WRITE : ST_READ;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram16k_dma_ctr.sv
`default_nettype none
// ============================================================================
// Module   : ram16k_dma_ctr
// Purpose  : Loadable WIDTH-bit counter wrapping modulo 2^WIDTH; counts up,
//            or down when DOWN=1. Load has priority over enable.
// Revision : 1.0 - initial release
// ============================================================================
module ram16k_dma_ctr
    import ram16k_pkg::*;
#(
    parameter int WIDTH = ADDR_W,
    parameter bit DOWN  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en) begin
            count_d = DOWN ? (count_q - WIDTH'(1)) : (count_q + WIDTH'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/ram16k_dma.sv
`default_nettype none
// ============================================================================
// Module   : ram16k_dma
// Purpose  : Copy/fill DMA engine driving a RAM16k port (in/load/sel/out).
//            Optional macro RAM16K_DMA_VERIFY_EN adds a read-back VERIFY
//            cycle after every write and an err output.
// Revision : 1.0 - initial release
// ============================================================================
module ram16k_dma
    import ram16k_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W-1:0] len,
    input  logic [DATA_W-1:0] fill_val,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] mem_in,
    output logic              mem_load,
    output logic [ADDR_W-1:0] mem_sel,
    input  logic [DATA_W-1:0] mem_out
`ifdef RAM16K_DMA_VERIFY_EN
    ,
    output logic              err
`endif
);

    state_e            state_q, state_d;
    logic              mode_q, mode_d;
    logic [DATA_W-1:0] fill_q, fill_d;
    logic [DATA_W-1:0] data_q, data_d;
`ifdef RAM16K_DMA_VERIFY_EN
    logic              err_q, err_d;
`endif

    logic              accept;
    logic              ctr_en;
    logic [ADDR_W-1:0] src_ptr;
    logic [ADDR_W-1:0] dst_ptr;
    logic [ADDR_W-1:0] remaining;
    logic [DATA_W-1:0] wr_word;

    assign accept  = (state_q == ST_IDLE) && start;
    assign wr_word = (mode_q == MODE_FILL) ? fill_q : data_q;

    ram16k_dma_ctr #(.WIDTH(ADDR_W), .DOWN(1'b0)) u_src_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .load_val (src_addr),
        .en       (ctr_en),
        .count    (src_ptr)
    );

    ram16k_dma_ctr #(.WIDTH(ADDR_W), .DOWN(1'b0)) u_dst_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .load_val (dst_addr),
        .en       (ctr_en),
        .count    (dst_ptr)
    );

    ram16k_dma_ctr #(.WIDTH(ADDR_W), .DOWN(1'b1)) u_rem_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .load_val (len),
        .en       (ctr_en),
        .count    (remaining)
    );

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        fill_d   = fill_q;
        data_d   = data_q;
`ifdef RAM16K_DMA_VERIFY_EN
        err_d    = err_q;
`endif
        ctr_en   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        mem_load = 1'b0;
        mem_sel  = '0;
        mem_in   = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d = mode;
                    fill_d = fill_val;
`ifdef RAM16K_DMA_VERIFY_EN
                    err_d  = 1'b0;
`endif
                    state_d = (len == '0) ? ST_DONE : xfer_state(mode);
                end
            end
            ST_READ: begin
                busy    = 1'b1;
                mem_sel = src_ptr;
                data_d  = mem_out;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                busy     = 1'b1;
                mem_sel  = dst_ptr;
                mem_in   = wr_word;
                mem_load = 1'b1;
                ctr_en   = 1'b1;
`ifdef RAM16K_DMA_VERIFY_EN
                state_d  = ST_VERIFY;
`else
                state_d  = (remaining == ADDR_W'(1)) ? ST_DONE : xfer_state(mode_q);
`endif
            end
`ifdef RAM16K_DMA_VERIFY_EN
            // Pointers already advanced at the write edge; look one word back.
            ST_VERIFY: begin
                busy    = 1'b1;
                mem_sel = dst_ptr - ADDR_W'(1);
                if (mem_out != wr_word) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = (remaining == '0) ? ST_DONE : xfer_state(mode_q);
                end
            end
`endif
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_COPY;
            fill_q  <= '0;
            data_q  <= '0;
`ifdef RAM16K_DMA_VERIFY_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            fill_q  <= fill_d;
            data_q  <= data_d;
`ifdef RAM16K_DMA_VERIFY_EN
            err_q   <= err_d;
`endif
        end
    end

`ifdef RAM16K_DMA_VERIFY_EN
    assign err = err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram16k_dma.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram16k_dma
// Purpose  : Self-checking bench for ram16k_dma with a RAM16k model and a
//            word-array reference of the expected memory contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram16k_dma;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        start    = 1'b0;
    logic        mode     = 1'b0;
    logic [13:0] src_addr = '0;
    logic [13:0] dst_addr = '0;
    logic [13:0] len      = '0;
    logic [15:0] fill_val = '0;
    logic        busy;
    logic        done;
    logic [15:0] mem_in;
    logic        mem_load;
    logic [13:0] mem_sel;
    logic [15:0] mem_out;
`ifdef RAM16K_DMA_VERIFY_EN
    logic        err;
    localparam int WORD_CYC_COPY = 3;
    localparam int WORD_CYC_FILL = 2;
`else
    localparam int WORD_CYC_COPY = 2;
    localparam int WORD_CYC_FILL = 1;
`endif

    always #5 clk = ~clk;

    ram16k_dma dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .mode     (mode),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .fill_val (fill_val),
        .busy     (busy),
        .done     (done),
        .mem_in   (mem_in),
        .mem_load (mem_load),
        .mem_sel  (mem_sel),
        .mem_out  (mem_out)
`ifdef RAM16K_DMA_VERIFY_EN
        ,
        .err      (err)
`endif
    );

    // RAM16k model: unwritten words read as an address-derived pattern.
    bit   [15:0] ram    [16384];
    bit          ram_wr [16384];
    bit          stuck   = 1'b0;
    bit          tb_we   = 1'b0;
    logic [13:0] tb_addr = '0;
    logic [15:0] tb_data = '0;
    logic [15:0] ref_mem [16384];
    int          n_total = 0;
    int          n_bad   = 0;

    function automatic logic [15:0] init_val(input logic [13:0] a);
        return {a[5:0], a[13:6], 2'b10} ^ 16'h9C35;
    endfunction

    function automatic logic [15:0] ram_word(input logic [13:0] a);
        return ram_wr[a] ? ram[a] : init_val(a);
    endfunction

    function automatic logic [13:0] wrapa(input int x);
        return x[13:0];
    endfunction

    always @(posedge clk) begin
        if (mem_load) begin
            ram[mem_sel]    <= mem_in;
            ram_wr[mem_sel] <= 1'b1;
        end else if (tb_we) begin
            ram[tb_addr]    <= tb_data;
            ram_wr[tb_addr] <= 1'b1;
        end
    end

    always_comb begin
        mem_out = ram_wr[mem_sel] ? ram[mem_sel] : init_val(mem_sel);
        if (stuck && mem_sel == 14'h0200) mem_out[0] = 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic mem_compare(input string tag);
        int diffs = 0;
        for (int a = 0; a < 16384; a++) begin
            if (ram_word(14'(a)) !== ref_mem[a]) diffs++;
        end
        check(tag, 32'(diffs), 32'd0);
    endtask

    task automatic preload(input logic [13:0] a, input logic [15:0] v);
        @(negedge clk);
        tb_we = 1'b1; tb_addr = a; tb_data = v;
        @(negedge clk);
        tb_we = 1'b0;
        ref_mem[a] = v;
    endtask

    // Issue one command and check timing, write sequence and final memory.
    task automatic run_cmd(input logic md, input logic [13:0] s, input logic [13:0] d,
                           input logic [13:0] l, input logic [15:0] fv);
        int exp_busy;
        int busy_n  = 0;
        int load_n  = 0;
        int seq_bad = 0;
        int lat     = 0;
        bit seen    = 1'b0;
        for (int i = 0; i < int'(l); i++) begin
            ref_mem[wrapa(int'(d) + i)] = md ? fv : ref_mem[wrapa(int'(s) + i)];
        end
        exp_busy = (md ? WORD_CYC_FILL : WORD_CYC_COPY) * int'(l);
        @(negedge clk);
        start = 1'b1; mode = md; src_addr = s; dst_addr = d; len = l; fill_val = fv;
        @(posedge clk);
        #1 start = 1'b0;
        while (!seen && lat < exp_busy + 8) begin
            @(negedge clk);
            lat++;
            if (busy) busy_n++;
            if (mem_load) begin
                if (mem_sel !== wrapa(int'(d) + load_n)) seq_bad++;
                load_n++;
            end
            if (done) begin
                seen = 1'b1;
`ifdef RAM16K_DMA_VERIFY_EN
                check("err_clear", 32'(err), 32'd0);
`endif
            end
            // Junk commands while busy must be ignored.
            if (busy && $urandom_range(3) == 0) begin
                start = 1'b1; mode = 1'($urandom);
                src_addr = 14'($urandom); dst_addr = 14'($urandom);
                len = 14'($urandom); fill_val = 16'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("done_seen", 32'(seen), 32'd1);
        check("latency", 32'(lat), 32'(exp_busy + 1));
        check("busy_cycles", 32'(busy_n), 32'(exp_busy));
        check("load_count", 32'(load_n), 32'(l));
        check("load_addr_seq", 32'(seq_bad), 32'd0);
        @(negedge clk);
        check("done_one_cycle", {30'd0, done, busy}, 32'd0);
        mem_compare("mem_contents");
    endtask

    initial begin
        for (int a = 0; a < 16384; a++) ref_mem[a] = init_val(14'(a));

        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_load", 32'(mem_load), 32'd0);
        check("rst_sel", 32'(mem_sel), 32'd0);
        check("rst_in", 32'(mem_in), 32'd0);
`ifdef RAM16K_DMA_VERIFY_EN
        check("rst_err", 32'(err), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        run_cmd(1'b1, 14'h0000, 14'h0100, 14'd4, 16'hDEAF);
        for (int i = 0; i < 4; i++) check("fill_word", 32'(ram_word(14'(16'h0100 + i))), 32'hDEAF);

        preload(14'h3AFB, 16'hC0DE);
        preload(14'h3AFC, 16'h1234);
        run_cmd(1'b0, 14'h3AFB, 14'h088C, 14'd2, 16'h0000);
        check("copy_w0", 32'(ram_word(14'h088C)), 32'hC0DE);
        check("copy_w1", 32'(ram_word(14'h088D)), 32'h1234);

        run_cmd(1'b1, 14'h0000, 14'h3FFE, 14'd3, 16'hBEEF);
        check("wrap_w0", 32'(ram_word(14'h0000)), 32'hBEEF);
        check("wrap_untouched", 32'(ram_word(14'h0001)), 32'(init_val(14'h0001)));

        run_cmd(1'b1, 14'h0000, 14'h0777, 14'd0, 16'hFFFF);

        // Asynchronous reset while the second fill word is being driven.
        @(negedge clk);
        start = 1'b1; mode = 1'b1; src_addr = '0; dst_addr = 14'h0500; len = 14'd8; fill_val = 16'h5A5A;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_load", 32'(mem_load), 32'd0);
        check("arst_sel", 32'(mem_sel), 32'd0);
        ref_mem[14'h0500] = 16'h5A5A;
        @(negedge clk);
        rst_n = 1'b1;
        mem_compare("arst_mem");

`ifdef RAM16K_DMA_VERIFY_EN
        begin
            int lat = 0;
            int busy_n = 0;
            int load_n = 0;
            bit seen = 1'b0;
            logic err_at_done = 1'b0;
            stuck = 1'b1;
            @(negedge clk);
            start = 1'b1; mode = 1'b1; dst_addr = 14'h0200; len = 14'd4; fill_val = 16'h0001;
            @(posedge clk);
            #1 start = 1'b0;
            while (!seen && lat < 20) begin
                @(negedge clk);
                lat++;
                if (busy) busy_n++;
                if (mem_load) load_n++;
                if (done) begin seen = 1'b1; err_at_done = err; end
            end
            check("vfy_latency", 32'(lat), 32'd3);
            check("vfy_busy", 32'(busy_n), 32'd2);
            check("vfy_loads", 32'(load_n), 32'd1);
            check("vfy_err", 32'(err_at_done), 32'd1);
            ref_mem[14'h0200] = 16'h0001;
            stuck = 1'b0;
            @(negedge clk);
            mem_compare("vfy_mem");
        end
`endif

        for (int t = 0; t < 20; t++) begin
            logic [13:0] s;
            logic [13:0] d;
            s = 14'($urandom);
            d = (t % 4 == 0) ? 14'(16'h3FF0 + $urandom_range(15)) : 14'($urandom);
            if (t % 5 == 1) d = s + 14'($urandom_range(1, 6));
            run_cmd(1'($urandom), s, d, 14'($urandom_range(0, 24)), 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
